// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues sequential fetches, buffers in-order responses,
// and on redirect flushes the buffer while discarding responses still in flight.
module fetch_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_resp_valid,
    input  logic [31:0]            imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [XLEN-1:0]        out_pc,
    output logic                   misalign_err,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            misalign_q, misalign_d;
    logic [PW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic [PW-1:0]   tail_q, tail_d;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic [PW-1:0] occ;
    logic [PW-1:0] pending;
    logic [PW:0]   budget;
    logic          accept;
    logic          pop;
    logic          drop_resp;
    logic          fill_en;
    logic          resp_hit;

    // head..fill are filled slots, fill..tail are reserved slots awaiting data
    assign occ     = tail_q - head_q;
    assign pending = tail_q - fill_q;
    // Responses still owed to flushed requests hold memory capacity like live slots
    assign budget  = {1'b0, occ} + {1'b0, drop_cnt_q};

    assign imem_req_valid = !rst && (state_q == RUN) && (budget < FULL);
    assign imem_addr      = fetch_pc_q;
    assign out_valid      = !rst && (fill_q != head_q);
    assign out_inst       = inst_mem[head_q[AW-1:0]];
    assign out_pc         = pc_mem[head_q[AW-1:0]];
    assign misalign_err   = !rst && misalign_q;
    assign occupancy      = rst ? '0 : occ;

    assign accept    = imem_req_valid && imem_req_ready;
    assign pop       = out_valid && out_ready;
    assign drop_resp = imem_resp_valid && (drop_cnt_q != '0);
    assign fill_en   = imem_resp_valid && (drop_cnt_q == '0) && (pending != '0);
    assign resp_hit  = drop_resp || fill_en;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        drop_cnt_d = drop_cnt_q;
        head_d     = head_q;
        fill_d     = fill_q;
        tail_d     = tail_q;

        if (redirect_valid) begin
            head_d     = '0;
            fill_d     = '0;
            tail_d     = '0;
            // Everything in flight after this cycle's accept/response becomes stale
            drop_cnt_d = drop_cnt_q + pending + PW'(accept) - PW'(resp_hit);
            if (redirect_target[1:0] != 2'b00) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end else begin
                state_d    = RUN;
                misalign_d = 1'b0;
                fetch_pc_d = redirect_target;
            end
        end else begin
            if (accept) begin
                tail_d     = tail_q + PW'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (drop_resp) begin
                drop_cnt_d = drop_cnt_q - PW'(1);
            end
            if (fill_en) begin
                fill_d = fill_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_VECTOR;
            misalign_q <= 1'b0;
            drop_cnt_q <= '0;
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
            drop_cnt_q <= drop_cnt_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem[tail_q[AW-1:0]] <= fetch_pc_q;
        end
        if (fill_en) begin
            inst_mem[fill_q[AW-1:0]] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: queue-level reference model, in-order fixed-latency memory,
// directed scenarios with literal expectations.
module tb_fetch_sequencer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RV = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        misalign_err;
    logic [2:0]  occupancy;

    fetch_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .misalign_err(misalign_err), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic filled; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    // Reference model state
    logic [31:0] m_pc   = RV;
    logic        m_halt = 1'b0;
    logic        m_mis  = 1'b0;
    int          m_drop = 0;
    ent_t        mq[$];
    logic [31:0] log_pc[$];
    int          dropped = 0;
    int          acc_cnt = 0;

    // Memory model
    mreq_t pend[$];
    int    cyc = 0;
    int    lat = 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic exp_req();
        return !rst && !m_halt && ((mq.size() + m_drop) < DEPTH);
    endfunction

    function automatic logic exp_oval();
        return !rst && (mq.size() > 0) && mq[0].filled;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic        acc;
        logic        popv;
        logic        done;
        logic [31:0] pc_before;
        int          u;
        ent_t        e;
        mreq_t       r;
        if (rst) begin
            m_pc = RV; m_halt = 1'b0; m_mis = 1'b0; m_drop = 0;
            mq.delete(); pend.delete(); log_pc.delete();
            dropped = 0; acc_cnt = 0;
            return;
        end
        acc  = exp_req() && imem_req_ready;
        popv = exp_oval() && out_ready;
        if (imem_resp_valid) begin
            if (m_drop > 0) begin
                m_drop--;
                dropped++;
            end else begin
                done = 1'b0;
                for (int i = 0; i < mq.size(); i++) begin
                    if (!done && !mq[i].filled) begin
                        mq[i].filled = 1'b1;
                        mq[i].inst   = imem_resp_data;
                        done = 1'b1;
                    end
                end
            end
        end
        if (popv) begin
            log_pc.push_back(mq[0].pc);
            mq.delete(0);
        end
        pc_before = m_pc;
        if (acc) begin
            e.pc = m_pc; e.filled = 1'b0; e.inst = 32'h0;
            mq.push_back(e);
            r.addr = m_pc; r.due = cyc + lat;
            pend.push_back(r);
            m_pc = m_pc + 32'd4;
            acc_cnt++;
        end
        if (redirect_valid) begin
            u = 0;
            foreach (mq[i]) if (!mq[i].filled) u++;
            m_drop += u;
            mq.delete();
            if (redirect_target[1:0] != 2'b00) begin
                m_mis = 1'b1; m_halt = 1'b1; m_pc = pc_before;
            end else begin
                m_mis = 1'b0; m_halt = 1'b0; m_pc = redirect_target;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(pend[0].addr);
            pend.delete(0);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        tick();
        redirect_valid  = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [31:0] pc_exp);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk({name, "_seen"}, out_valid, 1);
        chk({name, "_pc"}, out_pc, pc_exp);
        chk({name, "_inst"}, out_inst, inst_of(pc_exp));
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("req_valid", imem_req_valid, exp_req());
        if (exp_req()) chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", out_valid, exp_oval());
        if (exp_oval()) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_inst", out_inst, mq[0].inst);
        end
        chk("misalign_err", misalign_err, !rst && m_mis);
        chk("occupancy", occupancy, rst ? 0 : mq.size());
    end

    initial begin
        logic [31:0] p_exp;
        int          n_log;
        int          n_drop;

        // Streaming, latency 1
        tick();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        do_reset();
        chk("boot_req_valid", imem_req_valid, 1);
        chk("boot_addr", imem_addr, 32'h0);
        tick();
        tick();
        chk("first_out_valid", out_valid, 1);
        chk("first_out_pc", out_pc, 32'h0);
        chk("first_out_inst", out_inst, inst_of(32'h0));
        tick();
        chk("second_out_pc", out_pc, 32'h4);
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 4; i++)
            chk("stream_seq", (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF, 32'(i * 4));

        // Back-pressure fills the buffer, then drains (reset mid-stream)
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        chk("full_occupancy", occupancy, 4);
        chk("full_req_valid", imem_req_valid, 0);
        chk("full_accepts", acc_cnt, 4);
        chk("full_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        for (int i = 0; i < 5; i++)
            chk("drain_seq", (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF, 32'(i * 4));

        // Redirect with three requests in flight, latency 3
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect(32'h100);
        chk("redir_drop_model", m_drop, 3);
        chk("redir_occupancy", occupancy, 0);
        chk("redir_out_valid", out_valid, 0);
        wait_out("redir", 32'h100);
        chk("redir_dropped", dropped, 3);

        // Misaligned redirect halts, aligned redirect recovers
        lat = 1;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        redirect(32'h102);
        chk("mis_flag", misalign_err, 1);
        chk("mis_req_valid", imem_req_valid, 0);
        chk("mis_occupancy", occupancy, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("halt_req_valid", imem_req_valid, 0);
        chk("halt_flag", misalign_err, 1);
        redirect(32'h200);
        chk("recover_flag", misalign_err, 0);
        chk("recover_req_valid", imem_req_valid, 1);
        chk("recover_addr", imem_addr, 32'h200);
        wait_out("recover", 32'h200);

        // Accept, fill, pop and redirect in the same cycle
        for (int i = 0; i < 3; i++) tick();
        chk("combo_pre_req", imem_req_valid, 1);
        chk("combo_pre_out", out_valid, 1);
        p_exp  = (mq.size() > 0) ? mq[0].pc : 32'hDEAD_BEEF;
        n_log  = log_pc.size();
        n_drop = dropped;
        redirect(32'h300);
        chk("combo_pop_count", log_pc.size(), n_log + 1);
        chk("combo_popped_pc", (log_pc.size() > 0) ? log_pc[$] : 32'hDEAD_BEEF, p_exp);
        chk("combo_drop_model", m_drop, 1);
        wait_out("combo", 32'h300);
        chk("combo_dropped", dropped, n_drop + 1);

        // PC wraps modulo 2^32
        redirect(32'hFFFF_FFFC);
        chk("wrap_req_valid", imem_req_valid, 1);
        chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_lo", imem_addr, 32'h0);
        wait_out("wrap_hi", 32'hFFFF_FFFC);
        tick();
        wait_out("wrap_lo", 32'h0);

        // Held request stays stable; stray response is ignored
        imem_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        chk("hold_accepts", acc_cnt, 0);
        chk("hold_addr", imem_addr, 32'h0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        tick();
        chk("stray_occupancy", occupancy, 0);
        chk("stray_out_valid", out_valid, 0);
        imem_req_ready = 1'b1;
        wait_out("after_stray", 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
